// File: rtl/ahb_pkg.sv
// AHB protocol encodings shared by the arbiter and its picker.
package ahb_pkg;

   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;

   typedef enum logic [2:0] {
      SINGLE = 3'd0, INCR   = 3'd1, WRAP4  = 3'd2, INCR4 = 3'd3,
      WRAP8  = 3'd4, INCR8  = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} hresp_e;

   // INCR is undefined-length, so it is treated like SINGLE: no beats are protected.
   function automatic logic [4:0] burst_beats(hburst_e b);
      case (b)
         WRAP4, INCR4:   burst_beats = 5'd4;
         WRAP8, INCR8:   burst_beats = 5'd8;
         WRAP16, INCR16: burst_beats = 5'd16;
         default:        burst_beats = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational 16-way rotating-priority picker: first set req bit at or after base wins.
module ahb_rr_picker
   import ahb_pkg::*;
(
   input  logic [15:0] req,
   input  logic [3:0]  base,
   input  logic        en_rr,
   output logic        valid,
   output logic [3:0]  idx
);

   logic [3:0] start;
   logic [3:0] j;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      j     = '0;
      start = en_rr ? base : 4'd0;
      // 4-bit index arithmetic wraps naturally around the 16 slots
      for (int i = 0; i < 16; i++) begin
         j = start + 4'(i);
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = j;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: registered one-hot grant, burst/lock aware handover, registered HMASTER/HMASTLOCK.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS    = 16,
   parameter int DEFAULT_MASTER = 0,
   parameter int ROUND_ROBIN    = 1
) (
   input  logic        HCLK,
   input  logic        HRST_N,
   input  logic [15:0] HBUSREQ_i,
   input  logic [15:0] HLOCK_i,
   input  logic [1:0]  HTRANS_i,
   input  logic [2:0]  HBURST_i,
   input  logic        HREADY_i,
   input  logic [1:0]  HRESP_i,
   output logic [15:0] HGRANT_o,
   output logic [3:0]  HMASTER_o,
   output logic        HMASTLOCK_o
);

   localparam logic [3:0]  DEF  = 4'(DEFAULT_MASTER);
   localparam logic [3:0]  LAST = 4'(NUM_MASTERS - 1);
   localparam logic [15:0] MASK = 16'((32'd1 << NUM_MASTERS) - 32'd1);
   localparam logic        EN_RR = (ROUND_ROBIN != 0);

   htrans_e    trans;
   hresp_e     resp;
   logic [3:0] cnt, cnt_next;
   logic [3:0] grant_idx, rr_ptr, base;
   logic [15:0] req;
   logic       pick_valid;
   logic [3:0] pick_idx;
   logic       arb_ok;

   assign trans = htrans_e'(HTRANS_i);
   assign resp  = hresp_e'(HRESP_i);

   // Remaining SEQ beats of the owner's burst after the address being accepted this edge.
   always_comb begin
      cnt_next = cnt;
      if (HREADY_i) begin
         if (resp != OKAY) begin
            cnt_next = '0;
         end else begin
            case (trans)
               NONSEQ:  cnt_next = 4'(burst_beats(hburst_e'(HBURST_i)) - 5'd1);
               SEQ:     cnt_next = (cnt != '0) ? cnt - 4'd1 : '0;
               BUSY:    cnt_next = cnt;
               default: cnt_next = '0;
            endcase
         end
      end
   end

   assign arb_ok = !HLOCK_i[grant_idx] && (cnt_next <= 4'd1);
   assign req    = (HBUSREQ_i | HLOCK_i) & MASK;
   assign base   = (rr_ptr >= LAST) ? 4'd0 : rr_ptr + 4'd1;

   ahb_rr_picker u_picker (
      .req   (req),
      .base  (base),
      .en_rr (EN_RR),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) begin
         cnt         <= '0;
         HGRANT_o    <= 16'd1 << DEF;
         grant_idx   <= DEF;
         rr_ptr      <= DEF;
         HMASTER_o   <= DEF;
         HMASTLOCK_o <= 1'b0;
      end else begin
         cnt <= cnt_next;
         if (arb_ok) begin
            if (pick_valid) begin
               HGRANT_o  <= 16'd1 << pick_idx;
               grant_idx <= pick_idx;
               rr_ptr    <= pick_idx;
            end else begin
               // park on the default master without disturbing the rotation
               HGRANT_o  <= 16'd1 << DEF;
               grant_idx <= DEF;
            end
         end
         if (HREADY_i) begin
            HMASTER_o   <= grant_idx;
            HMASTLOCK_o <= HLOCK_i[grant_idx];
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with a cycle-level reference model and literal spot checks.
module tb_ahb_arbiter;

   localparam int N   = 8;
   localparam int DEF = 0;

   logic        HCLK = 1'b0;
   logic        HRST_N;
   logic [15:0] HBUSREQ, HLOCK;
   logic [1:0]  HTRANS, HRESP;
   logic [2:0]  HBURST;
   logic        HREADY;
   logic [15:0] HGRANT;
   logic [3:0]  HMASTER;
   logic        HMASTLOCK;

   int tests = 0;
   int fails = 0;

   ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .ROUND_ROBIN(1)) dut (
      .HCLK        (HCLK),
      .HRST_N      (HRST_N),
      .HBUSREQ_i   (HBUSREQ),
      .HLOCK_i     (HLOCK),
      .HTRANS_i    (HTRANS),
      .HBURST_i    (HBURST),
      .HREADY_i    (HREADY),
      .HRESP_i     (HRESP),
      .HGRANT_o    (HGRANT),
      .HMASTER_o   (HMASTER),
      .HMASTLOCK_o (HMASTLOCK)
   );

   always #5 HCLK = ~HCLK;

   // ---------------- reference model ----------------
   int m_cnt, m_gidx, m_rr, m_master;
   bit m_lock;

   function automatic int beats(input logic [2:0] b);
      case (b)
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         3'd6, 3'd7: return 16;
         default:    return 1;
      endcase
   endfunction

   // beats still owed after the address accepted at this edge
   function automatic int owed(input int c, input logic rd, input logic [1:0] rs,
                               input logic [1:0] tr, input logic [2:0] bu);
      if (!rd)        return c;
      if (rs != 2'd0) return 0;
      case (tr)
         2'd0:    return 0;
         2'd1:    return c;
         2'd2:    return beats(bu) - 1;
         default: return (c > 0) ? c - 1 : 0;
      endcase
   endfunction

   // walk the masters starting just after the last winner; -1 when nobody asks
   function automatic int pick(input logic [15:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int m;
         m = (last + k) % N;
         if (r[m]) return m;
      end
      return -1;
   endfunction

   always @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) begin
         m_cnt <= 0; m_gidx <= DEF; m_rr <= DEF; m_master <= DEF; m_lock <= 1'b0;
      end else begin
         if (!HLOCK[m_gidx] && owed(m_cnt, HREADY, HRESP, HTRANS, HBURST) <= 1) begin
            if (pick(HBUSREQ | HLOCK, m_rr) >= 0) begin
               m_gidx <= pick(HBUSREQ | HLOCK, m_rr);
               m_rr   <= pick(HBUSREQ | HLOCK, m_rr);
            end else begin
               m_gidx <= DEF;
            end
         end
         if (HREADY) begin
            m_master <= m_gidx;
            m_lock   <= HLOCK[m_gidx];
         end
         m_cnt <= owed(m_cnt, HREADY, HRESP, HTRANS, HBURST);
      end
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge HCLK) begin
      check("model_grant",  HGRANT, 16'(32'd1 << m_gidx));
      check("model_master", 16'(HMASTER), 16'(m_master));
      check("model_lock",   16'(HMASTLOCK), 16'(m_lock));
   end

   // drive inputs at a falling edge, then let one rising edge consume them
   task automatic drive(input logic [15:0] br, input logic [15:0] lk, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rd, input logic [1:0] rs);
      HBUSREQ = br; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rd; HRESP = rs;
      @(negedge HCLK);
   endtask

   localparam logic [1:0] TI = 2'd0, TN = 2'd2, TS = 2'd3;
   localparam logic [2:0] BSINGLE = 3'd0, BINCR4 = 3'd3, BINCR8 = 3'd5, BINCR16 = 3'd7;

   initial begin
      HRST_N = 1'b0;
      HBUSREQ = '0; HLOCK = '0; HTRANS = TI; HBURST = BSINGLE; HREADY = 1'b1; HRESP = 2'd0;
      @(negedge HCLK); @(negedge HCLK);
      check("rst_grant", HGRANT, 16'h0001);
      check("rst_master", 16'(HMASTER), 16'h0);
      check("rst_lock", 16'(HMASTLOCK), 16'h0);
      HRST_N = 1'b1;

      // 1. idle park
      for (int i = 0; i < 3; i++) drive(16'h0, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      check("park_grant", HGRANT, 16'h0001);
      check("park_master", 16'(HMASTER), 16'h0);

      // 2. round robin between M1 and M2 with single transfers
      drive(16'h0006, 16'h0, TN, BSINGLE, 1'b1, 2'd0);
      check("rr_g1", HGRANT, 16'h0002); check("rr_m1", 16'(HMASTER), 16'h0);
      drive(16'h0006, 16'h0, TN, BSINGLE, 1'b1, 2'd0);
      check("rr_g2", HGRANT, 16'h0004); check("rr_m2", 16'(HMASTER), 16'h1);
      drive(16'h0006, 16'h0, TN, BSINGLE, 1'b1, 2'd0);
      check("rr_g3", HGRANT, 16'h0002); check("rr_m3", 16'(HMASTER), 16'h2);

      // 3. INCR8 by M1, M2 joins at beat 2
      drive(16'h0002, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      drive(16'h0002, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      check("b8_owner", 16'(HMASTER), 16'h1);
      drive(16'h0002, 16'h0, TN, BINCR8, 1'b1, 2'd0);
      for (int b = 2; b <= 6; b++) drive(16'h0006, 16'h0, TS, BINCR8, 1'b1, 2'd0);
      check("b8_hold_beat6", HGRANT, 16'h0002);
      drive(16'h0006, 16'h0, TS, BINCR8, 1'b1, 2'd0);
      check("b8_move_beat7", HGRANT, 16'h0004);
      check("b8_master_beat7", 16'(HMASTER), 16'h1);
      drive(16'h0004, 16'h0, TS, BINCR8, 1'b1, 2'd0);
      check("b8_master_beat8", 16'(HMASTER), 16'h2);

      // 4. wait states on the last beat of an INCR4 by M2
      drive(16'h0004, 16'h0, TN, BINCR4, 1'b1, 2'd0);
      drive(16'h0004, 16'h0, TS, BINCR4, 1'b1, 2'd0);
      drive(16'h0006, 16'h0, TS, BINCR4, 1'b1, 2'd0);
      check("ws_grant", HGRANT, 16'h0002);
      for (int w = 0; w < 3; w++) begin
         drive(16'h0002, 16'h0, TS, BINCR4, 1'b0, 2'd0);
         check("ws_master_hold", 16'(HMASTER), 16'h2);
      end
      drive(16'h0002, 16'h0, TS, BINCR4, 1'b1, 2'd0);
      check("ws_master_move", 16'(HMASTER), 16'h1);

      // 5. M3 locked across two INCR4 bursts while M0 requests
      drive(16'h0009, 16'h0008, TI, BSINGLE, 1'b1, 2'd0);
      check("lk_grant", HGRANT, 16'h0008);
      drive(16'h0009, 16'h0008, TI, BSINGLE, 1'b1, 2'd0);
      for (int r = 0; r < 2; r++) begin
         drive(16'h0009, 16'h0008, TN, BINCR4, 1'b1, 2'd0);
         check("lk_grant_hold", HGRANT, 16'h0008);
         check("lk_mastlock", 16'(HMASTLOCK), 16'h1);
         for (int s = 0; s < 3; s++) begin
            drive(16'h0009, 16'h0008, TS, BINCR4, 1'b1, 2'd0);
            check("lk_grant_hold", HGRANT, 16'h0008);
            check("lk_mastlock", 16'(HMASTLOCK), 16'h1);
         end
      end
      drive(16'h0001, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      check("lk_release", HGRANT, 16'h0001);
      check("lk_unlock", 16'(HMASTLOCK), 16'h0);

      // 6. ERROR during INCR16, and ERROR racing a NONSEQ
      drive(16'h0004, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      drive(16'h0004, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      check("er_owner", 16'(HMASTER), 16'h2);
      drive(16'h0006, 16'h0, TN, BINCR16, 1'b1, 2'd0);
      drive(16'h0006, 16'h0, TS, BINCR16, 1'b1, 2'd0);
      check("er_hold", HGRANT, 16'h0004);
      drive(16'h0006, 16'h0, TS, BINCR16, 1'b1, 2'd1);
      check("er_rearb", HGRANT, 16'h0002);
      drive(16'h0006, 16'h0, TN, BINCR8, 1'b1, 2'd1);
      check("er_nonseq", HGRANT, 16'h0004);
      drive(16'h0006, 16'h0, TS, BINCR8, 1'b1, 2'd0);
      check("er_cnt_cleared", HGRANT, 16'h0002);

      // reset in the middle of a burst
      drive(16'h0002, 16'h0, TN, BINCR16, 1'b1, 2'd0);
      drive(16'h0002, 16'h0, TS, BINCR16, 1'b1, 2'd0);
      HTRANS = TS;
      #2 HRST_N = 1'b0;
      #1;
      check("mid_rst_grant", HGRANT, 16'h0001);
      check("mid_rst_master", 16'(HMASTER), 16'h0);
      check("mid_rst_lock", 16'(HMASTLOCK), 16'h0);
      @(negedge HCLK);
      HRST_N = 1'b1;
      drive(16'h0006, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      check("post_rst_rr", HGRANT, 16'h0002);

      // requests above NUM_MASTERS are ignored
      drive(16'h1000, 16'h0, TI, BSINGLE, 1'b1, 2'd0);
      check("mask_park", HGRANT, 16'h0001);
      drive(16'h0000, 16'h1000, TI, BSINGLE, 1'b1, 2'd0);
      check("mask_lock_park", HGRANT, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
